// File: rtl/puf_rng_sequencer.sv
// Sequencer for the arbiter-PUF RNG core: serial seeding, warm-up, collection of
// validated bits into words, valid/ready delivery, and repetition/stall health checks.
// All outputs are registered and change on the same edge as the state register.
module puf_rng_sequencer #(
    parameter int unsigned SEED_LEN    = 128,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned WARMUP_CYC  = 64,
    parameter int unsigned RCT_LIMIT   = 32,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic                stop,
    input  logic [SEED_LEN-1:0] seed_in,
    input  logic                rng_rnd,
    input  logic                rng_valid,
    output logic                rng_init_vec,
    output logic                rng_load,
    output logic                rng_en,
    output logic [WORD_W-1:0]   word_out,
    output logic                word_valid,
    input  logic                word_ready,
    output logic                busy,
    output logic                health_err,
    output logic [1:0]          err_code
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StSeed    = 3'd1;
    localparam logic [2:0] StWarmup  = 3'd2;
    localparam logic [2:0] StCollect = 3'd3;
    localparam logic [2:0] StHold    = 3'd4;
    localparam logic [2:0] StFault   = 3'd5;

    localparam logic [1:0] ErrNone = 2'b00;
    localparam logic [1:0] ErrRep  = 2'b01;
    localparam logic [1:0] ErrTmo  = 2'b10;

    localparam int unsigned PhMax = (SEED_LEN > WARMUP_CYC) ? SEED_LEN : WARMUP_CYC;
    localparam int unsigned PhW   = (PhMax > 1) ? $clog2(PhMax) : 1;
    localparam int unsigned BitW  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int unsigned RepW  = $clog2(RCT_LIMIT + 1);
    localparam int unsigned TmoW  = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]          state_q, state_d;
    logic [SEED_LEN-1:0] seed_q, seed_d;
    logic [PhW-1:0]      phase_q, phase_d;
    // Only the first WORD_W-1 bits of a word live here; the last bit goes straight out.
    logic [WORD_W-2:0]   word_sh_q, word_sh_d;
    logic [BitW-1:0]     bit_q, bit_d;
    logic [RepW-1:0]     rep_q, rep_d;
    logic                last_q, last_d;
    logic [TmoW-1:0]     tmo_q, tmo_d;
    logic                stop_pend_q, stop_pend_d;

    logic                init_vec_d, load_d, en_d, valid_d, busy_d, herr_d;
    logic [WORD_W-1:0]   word_out_d;
    logic [1:0]          err_d;

    logic [RepW-1:0]     rep_next;
    logic [WORD_W-1:0]   word_next;
    logic [TmoW-1:0]     tmo_next;
    logic                enter_seed, go_idle;

    // Next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        phase_d     = phase_q;
        word_sh_d   = word_sh_q;
        bit_d       = bit_q;
        rep_d       = rep_q;
        last_d      = last_q;
        tmo_d       = tmo_q;
        stop_pend_d = stop_pend_q;
        init_vec_d  = 1'b0;
        load_d      = 1'b0;
        en_d        = 1'b0;
        valid_d     = 1'b0;
        word_out_d  = word_out;
        err_d       = err_code;
        herr_d      = health_err;
        enter_seed  = 1'b0;
        go_idle     = 1'b0;

        rep_next  = (rng_rnd == last_q) ? rep_q + RepW'(1) : RepW'(1);
        word_next = {word_sh_q, rng_rnd};
        tmo_next  = tmo_q + TmoW'(1);

        unique case (state_q)
            StIdle: begin
                // stop has priority over a coincident start
                if (start && !stop) enter_seed = 1'b1;
            end
            StSeed: begin
                if (stop) begin
                    go_idle = 1'b1;
                end else if (phase_q == PhW'(SEED_LEN - 1)) begin
                    state_d = StWarmup;
                    phase_d = '0;
                    en_d    = 1'b1;
                end else begin
                    phase_d    = phase_q + PhW'(1);
                    load_d     = 1'b1;
                    en_d       = 1'b1;
                    init_vec_d = seed_q[SEED_LEN-1];
                    seed_d     = seed_q << 1;
                end
            end
            StWarmup: begin
                if (stop) begin
                    go_idle = 1'b1;
                end else begin
                    en_d = 1'b1;
                    if (phase_q == PhW'(WARMUP_CYC - 1)) begin
                        state_d = StCollect;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + PhW'(1);
                    end
                end
            end
            StCollect: begin
                en_d = 1'b1;
                if (stop) begin
                    go_idle = 1'b1;
                end else if (rng_valid) begin
                    rep_d     = rep_next;
                    last_d    = rng_rnd;
                    tmo_d     = '0;
                    word_sh_d = word_next[WORD_W-2:0];
                    bit_d     = bit_q + BitW'(1);
                    // A repetition failure wins over a word completing on the same bit
                    if (rep_next == RepW'(RCT_LIMIT)) begin
                        state_d = StFault;
                        herr_d  = 1'b1;
                        err_d   = ErrRep;
                        en_d    = 1'b0;
                        bit_d   = '0;
                    end else if (bit_q == BitW'(WORD_W - 1)) begin
                        state_d    = StHold;
                        word_out_d = word_next;
                        valid_d    = 1'b1;
                        en_d       = 1'b0;
                        bit_d      = '0;
                    end
                end else begin
                    tmo_d = tmo_next;
                    if (tmo_next == TmoW'(TIMEOUT_CYC)) begin
                        state_d = StFault;
                        herr_d  = 1'b1;
                        err_d   = ErrTmo;
                        en_d    = 1'b0;
                        bit_d   = '0;
                    end
                end
            end
            StHold: begin
                valid_d     = 1'b1;
                // A stop seen while holding is remembered and honoured after the handshake
                stop_pend_d = stop_pend_q | stop;
                if (word_valid && word_ready) begin
                    valid_d     = 1'b0;
                    bit_d       = '0;
                    stop_pend_d = 1'b0;
                    if (stop || stop_pend_q) begin
                        go_idle = 1'b1;
                    end else begin
                        state_d = StCollect;
                        en_d    = 1'b1;
                    end
                end
            end
            StFault: begin
                if (stop) begin
                    go_idle = 1'b1;
                end else if (start) begin
                    enter_seed = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (go_idle) begin
            state_d     = StIdle;
            init_vec_d  = 1'b0;
            load_d      = 1'b0;
            en_d        = 1'b0;
            valid_d     = 1'b0;
            word_out_d  = '0;
            bit_d       = '0;
            stop_pend_d = 1'b0;
        end

        if (enter_seed) begin
            state_d     = StSeed;
            seed_d      = seed_in << 1;
            init_vec_d  = seed_in[SEED_LEN-1];
            load_d      = 1'b1;
            en_d        = 1'b1;
            valid_d     = 1'b0;
            phase_d     = '0;
            bit_d       = '0;
            rep_d       = '0;
            last_d      = 1'b0;
            tmo_d       = '0;
            stop_pend_d = 1'b0;
            word_out_d  = '0;
            herr_d      = 1'b0;
            err_d       = ErrNone;
        end

        busy_d = (state_d != StIdle) && (state_d != StFault);
    end

    // State, counters and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            seed_q       <= '0;
            phase_q      <= '0;
            word_sh_q    <= '0;
            bit_q        <= '0;
            rep_q        <= '0;
            last_q       <= 1'b0;
            tmo_q        <= '0;
            stop_pend_q  <= 1'b0;
            rng_init_vec <= 1'b0;
            rng_load     <= 1'b0;
            rng_en       <= 1'b0;
            word_out     <= '0;
            word_valid   <= 1'b0;
            busy         <= 1'b0;
            health_err   <= 1'b0;
            err_code     <= ErrNone;
        end else begin
            state_q      <= state_d;
            seed_q       <= seed_d;
            phase_q      <= phase_d;
            word_sh_q    <= word_sh_d;
            bit_q        <= bit_d;
            rep_q        <= rep_d;
            last_q       <= last_d;
            tmo_q        <= tmo_d;
            stop_pend_q  <= stop_pend_d;
            rng_init_vec <= init_vec_d;
            rng_load     <= load_d;
            rng_en       <= en_d;
            word_out     <= word_out_d;
            word_valid   <= valid_d;
            busy         <= busy_d;
            health_err   <= herr_d;
            err_code     <= err_d;
        end
    end

endmodule

// File: tb/tb_puf_rng_sequencer.sv
// Self-checking bench for puf_rng_sequencer with a behavioural model of word packing,
// repetition run length and stall timeout.
module tb_puf_rng_sequencer;

    localparam int SL  = 8;
    localparam int WW  = 8;
    localparam int WU  = 4;
    localparam int RCT = 32;
    localparam int TMO = 256;

    logic          clock;
    logic          reset_n;
    logic          start;
    logic          stop;
    logic [SL-1:0] seed_in;
    logic          rng_rnd;
    logic          rng_valid;
    logic          rng_init_vec;
    logic          rng_load;
    logic          rng_en;
    logic [WW-1:0] word_out;
    logic          word_valid;
    logic          word_ready;
    logic          busy;
    logic          health_err;
    logic [1:0]    err_code;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model state
    bit       m_idle, m_hold, m_fault, m_pend;
    bit       m_last;
    int       m_run, m_tmo, m_accepted;
    logic [1:0]    m_err;
    logic [WW-1:0] m_word;
    bit       m_bits[$];

    puf_rng_sequencer #(
        .SEED_LEN   (SL),
        .WORD_W     (WW),
        .WARMUP_CYC (WU),
        .RCT_LIMIT  (RCT),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .seed_in     (seed_in),
        .rng_rnd     (rng_rnd),
        .rng_valid   (rng_valid),
        .rng_init_vec(rng_init_vec),
        .rng_load    (rng_load),
        .rng_en      (rng_en),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .busy        (busy),
        .health_err  (health_err),
        .err_code    (err_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear();
        m_idle = 0; m_hold = 0; m_fault = 0; m_pend = 0;
        m_last = 0; m_run = 0; m_tmo = 0; m_accepted = 0;
        m_err = 2'b00; m_word = '0;
        m_bits.delete();
    endtask

    // One COLLECT/HOLD cycle: drive inputs, advance the model, compare all outputs
    task automatic model_cycle(input logic v, input logic r, input logic rdy,
                               input logic stp, input logic st);
        logic [WW-1:0] w;
        rng_valid = v; rng_rnd = r; word_ready = rdy; stop = stp; start = st;
        @(posedge clock);
        if (!(m_idle || m_fault)) begin
            if (m_hold) begin
                m_pend = m_pend | stp;
                if (rdy) begin
                    m_hold = 0;
                    if (m_pend) m_idle = 1;
                    m_pend = 0;
                end
            end else if (stp) begin
                m_idle = 1;
                m_bits.delete();
            end else if (v) begin
                m_run = (r == m_last) ? m_run + 1 : 1;
                m_last = r;
                m_tmo = 0;
                m_accepted++;
                m_bits.push_back(r);
                if (m_run == RCT) begin
                    m_fault = 1; m_err = 2'b01; m_bits.delete();
                end else if (m_bits.size() == WW) begin
                    w = '0;
                    foreach (m_bits[k]) w = {w[WW-2:0], m_bits[k]};
                    m_word = w; m_hold = 1; m_bits.delete();
                end
            end else begin
                m_tmo++;
                if (m_tmo == TMO) begin
                    m_fault = 1; m_err = 2'b10; m_bits.delete();
                end
            end
        end
        #1;
        start = 1'b0;
        n_total++;
        if (word_valid !== m_hold) $display("FAIL word_valid: got %b want %b", word_valid, m_hold);
        else n_pass++;
        n_total++;
        if (rng_en !== (!m_idle && !m_fault && !m_hold))
            $display("FAIL rng_en: got %b want %b", rng_en, (!m_idle && !m_fault && !m_hold));
        else n_pass++;
        n_total++;
        if (rng_load !== 1'b0) $display("FAIL rng_load_collect: got %b want 0", rng_load);
        else n_pass++;
        n_total++;
        if (busy !== (!m_idle && !m_fault))
            $display("FAIL busy: got %b want %b", busy, (!m_idle && !m_fault));
        else n_pass++;
        n_total++;
        if (health_err !== m_fault) $display("FAIL health_err: got %b want %b", health_err, m_fault);
        else n_pass++;
        n_total++;
        if (err_code !== m_err) $display("FAIL err_code: got %b want %b", err_code, m_err);
        else n_pass++;
        if (m_hold) begin
            n_total++;
            if (word_out !== m_word) $display("FAIL word_out: got %h want %h", word_out, m_word);
            else n_pass++;
        end
        if (m_idle) begin
            n_total++;
            if (word_out !== '0) $display("FAIL word_out_idle: got %h want 0", word_out);
            else n_pass++;
        end
    endtask

    // Start a seed sequence and check the seed and warm-up phases; ends in COLLECT
    task automatic do_seed(input logic [SL-1:0] s);
        stop = 0; word_ready = 0; seed_in = s; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < SL; i++) begin
            n_total++;
            if (rng_load !== 1'b1) $display("FAIL seed_load[%0d]: got %b want 1", i, rng_load);
            else n_pass++;
            n_total++;
            if (rng_init_vec !== s[SL-1-i])
                $display("FAIL seed_bit[%0d]: got %b want %b", i, rng_init_vec, s[SL-1-i]);
            else n_pass++;
            n_total++;
            if (rng_en !== 1'b1 || busy !== 1'b1 || word_valid !== 1'b0)
                $display("FAIL seed_ctrl[%0d]: got en=%b busy=%b wv=%b want 1 1 0",
                         i, rng_en, busy, word_valid);
            else n_pass++;
            n_total++;
            if (health_err !== 1'b0 || err_code !== 2'b00)
                $display("FAIL seed_err[%0d]: got %b/%b want 0/00", i, health_err, err_code);
            else n_pass++;
            rng_valid = 1'($urandom); rng_rnd = 1'($urandom);
            tick();
        end
        for (int i = 0; i < WU; i++) begin
            n_total++;
            if (rng_load !== 1'b0 || rng_en !== 1'b1 || busy !== 1'b1)
                $display("FAIL warmup[%0d]: got load=%b en=%b busy=%b want 0 1 1",
                         i, rng_load, rng_en, busy);
            else n_pass++;
            // Bits offered during warm-up must not reach the word
            rng_valid = 1'b1; rng_rnd = 1'($urandom);
            tick();
        end
        model_clear();
    endtask

    task automatic go_idle();
        stop = 1; word_ready = 1; rng_valid = 0; start = 0;
        tick();
        tick();
        stop = 0; word_ready = 0;
        n_total++;
        if (busy !== 1'b0 || word_valid !== 1'b0 || rng_en !== 1'b0)
            $display("FAIL go_idle: got busy=%b wv=%b en=%b want 0 0 0", busy, word_valid, rng_en);
        else n_pass++;
        model_clear();
        m_idle = 1;
    endtask

    task automatic test_reset();
        reset_n = 1; start = 0; stop = 0; seed_in = '0;
        rng_rnd = 0; rng_valid = 0; word_ready = 0;
        #2 reset_n = 0;
        tick();
        tick();
        n_total++;
        if ({rng_init_vec, rng_load, rng_en, word_out, word_valid, busy, health_err, err_code} !== '0)
            $display("FAIL reset_outputs: got iv=%b ld=%b en=%b w=%h wv=%b busy=%b he=%b ec=%b want 0",
                     rng_init_vec, rng_load, rng_en, word_out, word_valid, busy, health_err, err_code);
        else n_pass++;
        reset_n = 1;
        tick();
        n_total++;
        if (busy !== 1'b0 || rng_en !== 1'b0) $display("FAIL idle_after_reset: busy=%b en=%b want 0 0", busy, rng_en);
        else n_pass++;
    endtask

    task automatic test_seed();
        do_seed(8'hA5);
    endtask

    task automatic test_word_pack();
        logic [WW-1:0] seq;
        seq = 8'b1101_0010;
        for (int i = 0; i < WW; i++) model_cycle(1'b1, seq[WW-1-i], 1'b0, 1'b0, 1'b0);
        n_total++;
        if (word_out !== 8'hD2 || word_valid !== 1'b1 || rng_en !== 1'b0)
            $display("FAIL pack_d2: got w=%h wv=%b en=%b want d2 1 0", word_out, word_valid, rng_en);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            model_cycle(1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
            n_total++;
            if (word_out !== 8'hD2 || word_valid !== 1'b1)
                $display("FAIL hold_stable[%0d]: got w=%h wv=%b want d2 1", i, word_out, word_valid);
            else n_pass++;
        end
        model_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_total++;
        if (word_valid !== 1'b0 || rng_en !== 1'b1)
            $display("FAIL accept: got wv=%b en=%b want 0 1", word_valid, rng_en);
        else n_pass++;
        for (int i = 0; i < WW + 2; i++) model_cycle(1'b1, 1'($urandom), 1'b1, 1'b0, 1'b0);
        go_idle();
    endtask

    task automatic test_alternate();
        int first;
        first = 0;
        do_seed(8'($urandom));
        for (int i = 1; i <= 2 * WW + 4; i++) begin
            model_cycle(1'(i % 2), 1'($urandom), 1'b0, 1'b0, 1'b0);
            if (first == 0 && word_valid === 1'b1) first = i;
        end
        n_total++;
        if (first != 2 * WW - 1) $display("FAIL alternate_latency: got %0d want %0d", first, 2 * WW - 1);
        else n_pass++;
        go_idle();
    endtask

    task automatic test_random();
        do_seed(8'($urandom));
        for (int i = 0; i < 300; i++)
            model_cycle(1'($urandom_range(0, 99) < 70), 1'($urandom),
                        1'($urandom_range(0, 99) < 50), 1'b0, 1'($urandom_range(0, 19) == 0));
        go_idle();
    endtask

    task automatic test_stop_hold();
        do_seed(8'($urandom));
        for (int i = 0; i < WW; i++) model_cycle(1'b1, 1'(i % 2), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            model_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            n_total++;
            if (busy !== 1'b1 || word_valid !== 1'b1)
                $display("FAIL stop_hold_wait[%0d]: got busy=%b wv=%b want 1 1", i, busy, word_valid);
            else n_pass++;
        end
        model_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        n_total++;
        if (busy !== 1'b0 || word_valid !== 1'b0)
            $display("FAIL stop_hold_exit: got busy=%b wv=%b want 0 0", busy, word_valid);
        else n_pass++;
        stop = 0; word_ready = 0;
    endtask

    task automatic test_stop_collect();
        do_seed(8'($urandom));
        for (int i = 0; i < 3; i++) model_cycle(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
        model_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        stop = 0;
        // start and stop together in IDLE: stays idle
        start = 1; stop = 1;
        tick();
        start = 0; stop = 0;
        n_total++;
        if (busy !== 1'b0 || rng_load !== 1'b0)
            $display("FAIL start_stop_idle: got busy=%b load=%b want 0 0", busy, rng_load);
        else n_pass++;
    endtask

    task automatic test_rct();
        int first;
        first = 0;
        do_seed(8'($urandom));
        for (int i = 1; i <= 60 && !m_fault; i++) begin
            model_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            if (first == 0 && health_err === 1'b1) first = i;
        end
        // 32 bits plus one accept cycle for each of the three full words
        n_total++;
        if (first != RCT + 3) $display("FAIL rct_cycle: got %0d want %0d", first, RCT + 3);
        else n_pass++;
        n_total++;
        if (health_err !== 1'b1 || err_code !== 2'b01 || rng_en !== 1'b0)
            $display("FAIL rct_fault: got he=%b ec=%b en=%b want 1 01 0", health_err, err_code, rng_en);
        else n_pass++;
        do_seed(8'($urandom));
        go_idle();
    endtask

    task automatic test_timeout();
        int first;
        first = 0;
        do_seed(8'($urandom));
        for (int i = 1; i <= TMO; i++) begin
            model_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (first == 0 && err_code === 2'b10) first = i;
        end
        n_total++;
        if (first != TMO) $display("FAIL timeout_cycle: got %0d want %0d", first, TMO);
        else n_pass++;
        stop = 1;
        tick();
        stop = 0;
        n_total++;
        if (busy !== 1'b0 || health_err !== 1'b1 || err_code !== 2'b10)
            $display("FAIL fault_stop: got busy=%b he=%b ec=%b want 0 1 10", busy, health_err, err_code);
        else n_pass++;
    endtask

    task automatic test_reset_mid_seed();
        seed_in = 8'hA5; start = 1;
        tick();
        start = 0;
        tick();
        tick();
        n_total++;
        if (rng_load !== 1'b1) $display("FAIL mid_seed_load: got %b want 1", rng_load);
        else n_pass++;
        #2 reset_n = 0;
        #1;
        n_total++;
        if ({rng_init_vec, rng_load, rng_en, word_out, word_valid, busy, health_err, err_code} !== '0)
            $display("FAIL async_reset: got iv=%b ld=%b en=%b w=%h wv=%b busy=%b he=%b ec=%b want 0",
                     rng_init_vec, rng_load, rng_en, word_out, word_valid, busy, health_err, err_code);
        else n_pass++;
        tick();
        reset_n = 1;
        tick();
        n_total++;
        if (busy !== 1'b0 || rng_load !== 1'b0)
            $display("FAIL post_reset_idle: got busy=%b load=%b want 0 0", busy, rng_load);
        else n_pass++;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_seed();
        test_word_pack();
        test_alternate();
        test_random();
        test_stop_hold();
        test_stop_collect();
        test_rct();
        test_timeout();
        test_reset_mid_seed();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/puf_rng_sequencer.md
Name: puf_rng_sequencer

Overview:
- Controller that sequences the arbiter-PUF random number generator core: seeds its challenge shift register, runs a warm-up, and then gathers PUF output bits that pass the core's validity check.
- Packs gathered bits into words and delivers them on a valid/ready handshake.
- Runs a repetition-count health test and a no-valid-bit timeout. Either failure freezes the core until it is reseeded.
- Sits between the RNG core and the consumer bus.

Parameters:
- SEED_LEN, 128, challenge register length; equals the number of serial seed bits shifted in.
- WORD_W, 32, output word width in bits.
- WARMUP_CYC, 64, cycles the core runs after seeding before any bit is collected.
- RCT_LIMIT, 32, number of consecutive identical valid bits that counts as a health failure.
- TIMEOUT_CYC, 256, number of consecutive COLLECT cycles with rng_valid=0 that counts as a stall failure.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle pulse; begins a seed sequence.
- stop  in  1  level; returns the block to IDLE.
- seed_in  in  SEED_LEN  seed vector, captured on an accepted start.
- rng_rnd  in  1  core random bit.
- rng_valid  in  1  core validity flag (PUF outputs agree).
- rng_init_vec  out  1  serial seed bit to the core.
- rng_load  out  1  selects the seed path into the core shift register.
- rng_en  out  1  core shift-register enable.
- word_out  out  WORD_W  assembled random word.
- word_valid  out  1  word_out holds a word.
- word_ready  in  1  consumer accepts the word.
- busy  out  1  state is not IDLE and not FAULT.
- health_err  out  1  sticky fault flag.
- err_code  out  2  fault cause: 00 none, 01 repetition, 10 timeout.

Behaviour:
- Reset values: every output 0, state IDLE, all counters and registers 0.
- States: IDLE, SEED, WARMUP, COLLECT, HOLD, FAULT.
- Output decode is registered. Every output is a flop updated on the same edge as the state.
- IDLE:
  - Outputs low.
  - start=1 captures seed_in into seed_sh and moves to SEED.
  - start=1 with stop=1 in the same cycle: stop wins, the block stays in IDLE.
- SEED:
  - rng_load=1, rng_en=1, rng_init_vec=seed_sh[SEED_LEN-1]; seed_sh shifts left each cycle.
  - Exactly SEED_LEN cycles, MSB first, then WARMUP.
- WARMUP:
  - rng_load=0, rng_en=1; rng_rnd is ignored.
  - Exactly WARMUP_CYC cycles, then COLLECT.
- COLLECT:
  - rng_en=1.
  - Each cycle with rng_valid=1: word_sh <= {word_sh[WORD_W-2:0], rng_rnd}, bit_cnt += 1.
  - When the WORD_W-th bit is captured: word_out <= the completed word, word_valid=1 on the next cycle, state becomes HOLD, rng_en=0.
  - Each cycle with rng_valid=0: tmo_cnt += 1. Any valid bit clears tmo_cnt.
  - tmo_cnt reaching TIMEOUT_CYC: FAULT, err_code=10.
- Repetition test:
  - Runs on valid bits in COLLECT only.
  - rep_cnt resets to 1 when rng_rnd differs from the last valid bit, otherwise increments.
  - rep_cnt reaching RCT_LIMIT: FAULT, err_code=01. This overrides word completion in the same cycle.
  - rep_cnt and the last-bit register persist across words. They clear on entry to SEED.
- HOLD:
  - word_valid=1, word_out stable, rng_en=0 (core frozen).
  - word_valid&&word_ready: word_valid=0 next cycle, bit_cnt=0, return to COLLECT.
  - No timeout counting in HOLD.
- FAULT:
  - health_err=1, err_code held, rng_en=0, rng_load=0, word_valid=0, partial word discarded.
  - start reseeds (SEED) and clears health_err and err_code.
  - stop goes to IDLE and keeps health_err and err_code.
- stop in SEED, WARMUP or COLLECT: IDLE next cycle, partial word discarded.
- stop in HOLD: ignored until the handshake completes, then IDLE instead of COLLECT.
- start while busy: ignored.
- Asynchronous reset at any point: immediate return to reset values. A partial seed or word is lost.

Test Plan:
- SEED_LEN=8, WARMUP_CYC=4, seed_in=8'hA5, start pulse → rng_load=1 for exactly 8 cycles, rng_init_vec sequence 1,0,1,0,0,1,0,1; then 4 cycles with rng_en=1, rng_load=0; then COLLECT.
- WORD_W=8, rng_valid=1, rng_rnd sequence 1,1,0,1,0,0,1,0 → word_out=8'hD2, word_valid=1 one cycle after the last bit, rng_en=0 while held.
- Hold word_ready=0 for 5 cycles, then 1 → word_out stable and word_valid=1 throughout; word_valid=0 the cycle after acceptance; collection resumes.
- Alternate rng_valid 1/0 → only valid-cycle bits are packed; word completes after 2*WORD_W-1 cycles.
- RCT_LIMIT=32, constant rng_rnd=1 with rng_valid=1 → FAULT on the 32nd bit, err_code=01, health_err=1, rng_en=0; a later start clears the flag and reseeds.
- rng_valid=0 for TIMEOUT_CYC=256 cycles in COLLECT → err_code=10. Separately: reset_n low mid-SEED → all outputs 0 immediately; stop during HOLD → IDLE only after the handshake.
